// File: rtl/q2_run_ctrl.sv
// Q2 front-panel run/stop/step sequencer: debounced switches, run FSM and cdiv phase divider.
// Define Q2_CYCLE_LIMIT_EN to add an automatic stop after CYCLE_LIMIT run-cycles (limit_hit port).
module q2_run_ctrl #(
    parameter int unsigned DEBOUNCE    = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned CYCLE_LIMIT = 1000
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start_sw,
    input  logic             stop_sw,
    input  logic             step_sw,
    input  logic             step_ins,
    input  logic             fetch,
    input  logic             halt,
    output logic             cen,
    output logic             cdiv,
    output logic             ncdiv,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycles
`ifdef Q2_CYCLE_LIMIT_EN
    ,
    output logic             limit_hit
`endif
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {StStopped, StRun, StStepCyc, StStepIns, StHalted} state_e;

    state_e          state_q;
    logic [2:0]      raw;
    logic [2:0]      sync1_q, sync2_q, level_q, press_q;
    logic [DB_W-1:0] db_cnt_q [3];
    logic            start_press, stop_press, step_press;
    logic            stop_pend_q, step_done_q;
    logic            lim_reached;

    // Bit order: 0 = start, 1 = stop, 2 = step.
    assign raw         = {step_sw, stop_sw, start_sw};
    assign start_press = press_q[0];
    assign stop_press  = press_q[1];
    assign step_press  = press_q[2];
    assign ncdiv       = ~cdiv;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] == level_q[i]) begin
                    db_cnt_q[i] <= '0;
                    press_q[i]  <= 1'b0;
                end else if (db_cnt_q[i] == DB_W'(DEBOUNCE - 1)) begin
                    level_q[i]  <= sync2_q[i];
                    db_cnt_q[i] <= '0;
                    press_q[i]  <= sync2_q[i];
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
                    press_q[i]  <= 1'b0;
                end
            end
        end
    end

`ifdef Q2_CYCLE_LIMIT_EN
    localparam int unsigned LIM_W = $clog2(CYCLE_LIMIT + 1);
    logic [LIM_W-1:0] lim_q;
    // lim_q counts cycles completed since the accepted start/step press.
    assign lim_reached = (lim_q + LIM_W'(1)) == LIM_W'(CYCLE_LIMIT);
`else
    logic unused_cycle_limit;
    assign lim_reached        = 1'b0;
    assign unused_cycle_limit = ^CYCLE_LIMIT;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= StStopped;
            cen         <= 1'b0;
            cdiv        <= 1'b0;
            running     <= 1'b0;
            halted      <= 1'b0;
            cycles      <= '0;
            stop_pend_q <= 1'b0;
            step_done_q <= 1'b0;
`ifdef Q2_CYCLE_LIMIT_EN
            lim_q       <= '0;
            limit_hit   <= 1'b0;
`endif
        end else begin
`ifdef Q2_CYCLE_LIMIT_EN
            limit_hit <= 1'b0;
`endif
            case (state_q)
                StStopped, StHalted: begin
                    // Stop beats start, start beats step; step is ignored while halted.
                    if (start_press && !stop_press) begin
                        state_q     <= StRun;
                        cen         <= 1'b1;
                        running     <= 1'b1;
                        halted      <= 1'b0;
                        stop_pend_q <= 1'b0;
                        step_done_q <= 1'b0;
`ifdef Q2_CYCLE_LIMIT_EN
                        lim_q       <= '0;
`endif
                    end else if (step_press && !stop_press && state_q == StStopped) begin
                        state_q     <= step_ins ? StStepIns : StStepCyc;
                        cen         <= 1'b1;
                        running     <= 1'b1;
                        stop_pend_q <= 1'b0;
                        step_done_q <= 1'b0;
`ifdef Q2_CYCLE_LIMIT_EN
                        lim_q       <= '0;
`endif
                    end
                end
                default: begin
                    cdiv        <= ~cdiv;
                    stop_pend_q <= stop_pend_q | stop_press;
                    if (cdiv) begin
                        cycles      <= cycles + CNT_W'(1);
                        step_done_q <= 1'b1;
`ifdef Q2_CYCLE_LIMIT_EN
                        lim_q       <= lim_q + LIM_W'(1);
`endif
                        if (halt) begin
                            state_q     <= StHalted;
                            cen         <= 1'b0;
                            running     <= 1'b0;
                            halted      <= 1'b1;
                            stop_pend_q <= 1'b0;
                        end else if (stop_pend_q || lim_reached || state_q == StStepCyc ||
                                     (state_q == StStepIns && fetch && step_done_q)) begin
                            state_q     <= StStopped;
                            cen         <= 1'b0;
                            running     <= 1'b0;
                            stop_pend_q <= 1'b0;
`ifdef Q2_CYCLE_LIMIT_EN
                            limit_hit   <= lim_reached;
`endif
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_q2_run_ctrl.sv
// Bench for q2_run_ctrl: directed panel scenarios plus random switch episodes against a
// cycle-count reference model. Build with Q2_CYCLE_LIMIT_EN to cover the limit feature.
module tb_q2_run_ctrl;

    localparam int unsigned DEBOUNCE    = 4;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned CYCLE_LIMIT = 20;
`ifdef Q2_CYCLE_LIMIT_EN
    localparam bit LIM_EN = 1'b1;
`else
    localparam bit LIM_EN = 1'b0;
`endif
    localparam int MStop = 0, MRun = 1, MScyc = 2, MSins = 3, MHalt = 4;

    logic clk = 1'b0, nreset = 1'b0;
    logic start_sw = 1'b0, stop_sw = 1'b0, step_sw = 1'b0;
    logic step_ins = 1'b0, fetch = 1'b0, halt = 1'b0;
    logic cen, cdiv, ncdiv, running, halted;
    logic [CNT_W-1:0] cycles;
`ifdef Q2_CYCLE_LIMIT_EN
    logic limit_hit;
`endif

    q2_run_ctrl #(
        .DEBOUNCE   (DEBOUNCE),
        .CNT_W      (CNT_W),
        .CYCLE_LIMIT(CYCLE_LIMIT)
    ) dut (
        .clk      (clk),
        .nreset   (nreset),
        .start_sw (start_sw),
        .stop_sw  (stop_sw),
        .step_sw  (step_sw),
        .step_ins (step_ins),
        .fetch    (fetch),
        .halt     (halt),
        .cen      (cen),
        .cdiv     (cdiv),
        .ncdiv    (ncdiv),
        .running  (running),
        .halted   (halted),
        .cycles   (cycles)
`ifdef Q2_CYCLE_LIMIT_EN
        ,
        .limit_hit(limit_hit)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode, enabled clks and completed cycles per step as plain integers.
    int         m_mode, m_ticks, m_in_step, m_total;
    bit         m_pend, m_hit;
    bit   [2:0] m_lvl, m_press;
    logic [2:0] m_hist[$];
    bit         rand_in = 1'b0, auto_fetch = 1'b0, auto_halt = 1'b0;

    function automatic bit m_active();
        return m_mode == MRun || m_mode == MScyc || m_mode == MSins;
    endfunction

    task automatic model_reset();
        m_mode = MStop; m_ticks = 0; m_in_step = 0; m_total = 0;
        m_pend = 0; m_hit = 0; m_lvl = '0; m_press = '0;
        m_hist.delete();
        for (int k = 0; k < DEBOUNCE + 2; k++) m_hist.push_back(3'b000);
    endtask

    task automatic model_edge();
        bit boundary;
        bit all_diff;
        m_hit = 0;
        if (m_mode == MStop || m_mode == MHalt) begin
            if (!m_press[1] && m_press[0]) begin
                m_mode = MRun; m_ticks = 0; m_in_step = 0; m_pend = 0;
            end else if (!m_press[1] && m_press[2] && m_mode == MStop) begin
                m_mode = step_ins ? MSins : MScyc; m_ticks = 0; m_in_step = 0; m_pend = 0;
            end
        end else begin
            boundary = (m_ticks % 2) == 1;
            m_ticks++;
            if (boundary) begin
                m_total++;
                m_in_step++;
                if (halt) begin
                    m_mode = MHalt; m_pend = 0;
                end else begin
                    m_hit = LIM_EN && m_in_step == int'(CYCLE_LIMIT);
                    if (m_pend || m_mode == MScyc || m_hit ||
                        (m_mode == MSins && fetch && m_in_step >= 2)) begin
                        m_mode = MStop; m_pend = 0;
                    end
                end
            end
            if (m_active()) m_pend = m_pend | m_press[1];
        end
        // Level flips once DEBOUNCE samples, two clks old, all disagree with it.
        m_hist.push_back({step_sw, stop_sw, start_sw});
        if (m_hist.size() > DEBOUNCE + 2) void'(m_hist.pop_front());
        for (int i = 0; i < 3; i++) begin
            all_diff = 1;
            for (int k = 0; k < DEBOUNCE; k++) if (m_hist[k][i] == m_lvl[i]) all_diff = 0;
            if (all_diff) m_lvl[i] = ~m_lvl[i];
            m_press[i] = all_diff && m_lvl[i];
        end
    endtask

    task automatic compare_all();
        bit er;
        er = m_active();
        check("cen", cen, er);
        check("running", running, er);
        check("cdiv", cdiv, er ? m_ticks % 2 : 0);
        check("ncdiv", ncdiv, er ? 1 - m_ticks % 2 : 1);
        check("halted", halted, m_mode == MHalt);
        check("cycles", cycles, m_total % (1 << CNT_W));
`ifdef Q2_CYCLE_LIMIT_EN
        check("limit_hit", limit_hit, m_hit);
`endif
    endtask

    task automatic tick();
        if (rand_in) begin
            fetch = $urandom_range(0, 2) == 0;
            halt  = $urandom_range(0, 39) == 0;
        end
        if (auto_fetch) fetch = m_mode == MSins && (m_in_step == 0 || m_in_step == 3);
        if (auto_halt)  halt  = m_active() && m_in_step == 4 && m_ticks % 2 == 1;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic press(input bit [2:0] sw, input int hold_n, input int idle_n);
        {step_sw, stop_sw, start_sw} = sw;
        repeat (hold_n) tick();
        {step_sw, stop_sw, start_sw} = 3'b000;
        repeat (idle_n) tick();
    endtask

    // Called just after a tick; asserts reset in mid-period, away from both edges.
    task automatic async_reset();
        #3 nreset = 1'b0;
        model_reset();
        #1;
        check("rst_cen", cen, 0);
        check("rst_cdiv", cdiv, 0);
        check("rst_cycles", cycles, 0);
        compare_all();
        #2 nreset = 1'b1;
    endtask

    initial begin
        int first, cnt, c0;
        model_reset();
        #12;
        compare_all();
        nreset = 1'b1;

        press(3'b001, 3, 8);
        check("glitch_running", running, 0);

        first = 0;
        start_sw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (running && first == 0) first = k;
        end
        start_sw = 1'b0;
        check("start_latency", first, 7);
        repeat (4) tick();
        press(3'b010, DEBOUNCE + 1, 12);
        check("stop_running", running, 0);

        step_ins = 1'b0;
        c0 = m_total;
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step_sw = k < 6;
            tick();
            cnt += int'(cen);
        end
        check("step_cyc_cen_clks", cnt, 2);
        check("step_cyc_cycles", cycles, (c0 + 1) % (1 << CNT_W));

        step_ins = 1'b1;
        auto_fetch = 1'b1;
        c0 = m_total;
        for (int k = 0; k < 30; k++) begin
            step_sw = k < 6;
            tick();
        end
        auto_fetch = 1'b0;
        fetch = 1'b0;
        check("step_ins_cycles", cycles, (c0 + 4) % (1 << CNT_W));
        check("step_ins_stopped", running, 0);

        auto_halt = 1'b1;
        press(3'b001, 6, 22);
        auto_halt = 1'b0;
        halt = 1'b0;
        check("halt_halted", halted, 1);
        check("halt_cen", cen, 0);
        press(3'b100, 6, 10);
        check("halt_step_ignored", halted, 1);
        press(3'b001, 6, 6);
        check("restart_running", running, 1);
        check("restart_halted", halted, 0);
        press(3'b010, 6, 10);

        press(3'b011, 6, 10);
        check("start_stop_same_clk", running, 0);

        press(3'b001, 6, 5);
        async_reset();
        repeat (3) tick();

`ifdef Q2_CYCLE_LIMIT_EN
        async_reset();
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            start_sw = k < 6;
            tick();
            cnt += int'(limit_hit);
        end
        check("limit_pulses", cnt, 1);
        check("limit_cycles", cycles, 4);
        check("limit_stopped", running, 0);
`endif

        rand_in = 1'b1;
        for (int ep = 0; ep < 60; ep++) begin
            step_ins = $urandom_range(0, 1);
            press(3'($urandom_range(1, 7)), $urandom_range(1, DEBOUNCE + 6),
                  $urandom_range(0, 20));
            if ($urandom_range(0, 29) == 0) async_reset();
        end
        rand_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
